// File: rtl/cpu_mem_host.sv
// rtl/cpu_mem_host.sv - CPU instruction/data RAM responder with host load -> start -> run -> dump sequencer
// Optional run-cycle counter output enabled by defining CPU_MEM_HOST_CYCLE_COUNT_EN.
module cpu_mem_host #(
  parameter int IRAM_DEPTH = 256,
  parameter int DRAM_DEPTH = 256,
  parameter int DUMP_LEN   = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  iram_addr,
  output logic [15:0] iram_dout,
  input  logic [7:0]  dram_addr,
  input  logic [7:0]  dram_din,
  input  logic        dram_write,
  output logic [7:0]  dram_dout,
  output logic        start,
  input  logic        idle,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        busy
`ifdef CPU_MEM_HOST_CYCLE_COUNT_EN
  ,
  output logic [31:0] run_cycles
`endif
);
  localparam int IAW = (IRAM_DEPTH > 1) ? $clog2(IRAM_DEPTH) : 1;
  localparam int DAW = (DRAM_DEPTH > 1) ? $clog2(DRAM_DEPTH) : 1;
  localparam int PW  = (IAW > DAW) ? IAW : DAW;
  localparam int RW  = $clog2(DUMP_LEN + 1);

  typedef enum logic [2:0] {S_LOAD_I, S_LOAD_D, S_START, S_RUN, S_DUMP} state_e;

  state_e        state_q;
  logic [PW-1:0] wptr_q;
  logic [RW-1:0] rptr_q;
  logic          seen_busy_q;
  logic          start_q;
  logic          s_ready_q;
  logic          busy_q;
  logic          m_valid_q;
  logic          m_last_q;
  logic [7:0]    m_data_q;
  logic [15:0]   iram_dout_q;
  logic [7:0]    dram_dout_q;

  logic [15:0] iram_mem [IRAM_DEPTH];
  logic [7:0]  dram_mem [DRAM_DEPTH];

  logic [IAW-1:0] iram_idx;
  logic [IAW-1:0] iram_widx;
  logic [DAW-1:0] dram_idx;
  logic [DAW-1:0] dram_widx;
  logic [DAW-1:0] dump_idx;
  logic [7:0]     dram_wdata;
  logic           s_fire;
  logic           iram_we;
  logic           dram_we;
  logic           wptr_wrap;

  assign iram_idx  = IAW'(32'(iram_addr) % IRAM_DEPTH);
  assign dram_idx  = DAW'(32'(dram_addr) % DRAM_DEPTH);
  assign iram_widx = IAW'(wptr_q);
  assign dump_idx  = DAW'(rptr_q);
  assign s_fire    = s_valid & s_ready_q;
  assign wptr_wrap = (state_q == S_LOAD_I) ? (wptr_q == PW'(IRAM_DEPTH - 1))
                                           : (wptr_q == PW'(DRAM_DEPTH - 1));

  // DRAM has one write port shared by the loader and the CPU; they never overlap in state.
  assign iram_we    = s_fire & (state_q == S_LOAD_I);
  assign dram_we    = (s_fire & (state_q == S_LOAD_D)) | (dram_write & (state_q == S_RUN));
  assign dram_widx  = (state_q == S_RUN) ? dram_idx : DAW'(wptr_q);
  assign dram_wdata = (state_q == S_RUN) ? dram_din : s_data[7:0];

  always_ff @(posedge clk) begin
    if (iram_we) iram_mem[iram_widx] <= s_data;
    if (dram_we) dram_mem[dram_widx] <= dram_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_LOAD_I;
      wptr_q      <= '0;
      rptr_q      <= '0;
      seen_busy_q <= 1'b0;
      start_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      iram_dout_q <= '0;
      dram_dout_q <= '0;
    end else begin
      iram_dout_q <= iram_mem[iram_idx];
      dram_dout_q <= dram_mem[dram_idx];
      start_q     <= 1'b0;
      case (state_q)
        S_LOAD_I: begin
          s_ready_q <= 1'b1;
          if (s_fire) begin
            if (s_last) begin
              wptr_q  <= '0;
              state_q <= S_LOAD_D;
            end else begin
              wptr_q <= wptr_wrap ? '0 : wptr_q + 1'b1;
            end
          end
        end
        S_LOAD_D: begin
          s_ready_q <= 1'b1;
          if (s_fire) begin
            if (s_last) begin
              wptr_q    <= '0;
              state_q   <= S_START;
              s_ready_q <= 1'b0;
              start_q   <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              wptr_q <= wptr_wrap ? '0 : wptr_q + 1'b1;
            end
          end
        end
        S_START: begin
          seen_busy_q <= 1'b0;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          // Only an idle edge after the CPU has actually gone busy ends the run.
          if (!idle) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            seen_busy_q <= 1'b0;
            busy_q      <= 1'b0;
            rptr_q      <= '0;
            m_valid_q   <= 1'b0;
            state_q     <= S_DUMP;
          end
        end
        S_DUMP: begin
          if (!m_valid_q || m_ready) begin
            if (m_valid_q && m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              wptr_q    <= '0;
              s_ready_q <= 1'b1;
              state_q   <= S_LOAD_I;
            end else begin
              m_valid_q <= 1'b1;
              m_data_q  <= dram_mem[dump_idx];
              m_last_q  <= (rptr_q == RW'(DUMP_LEN - 1));
              rptr_q    <= rptr_q + 1'b1;
            end
          end
        end
        default: state_q <= S_LOAD_I;
      endcase
    end
  end

`ifdef CPU_MEM_HOST_CYCLE_COUNT_EN
  logic [31:0] run_cycles_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cycles_q <= '0;
    end else if ((state_q == S_LOAD_D) && s_fire && s_last) begin
      run_cycles_q <= '0;
    end else if ((state_q == S_RUN) && (run_cycles_q != '1)) begin
      run_cycles_q <= run_cycles_q + 1'b1;
    end
  end

  assign run_cycles = run_cycles_q;
`endif

  assign iram_dout = iram_dout_q;
  assign dram_dout = dram_dout_q;
  assign start     = start_q;
  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;

endmodule

// File: tb/tb_cpu_mem_host.sv
// tb/tb_cpu_mem_host.sv - self-checking bench for cpu_mem_host (load/run/dump rounds against a RAM model)
// Build with CPU_MEM_HOST_CYCLE_COUNT_EN defined to also cover run_cycles.
`timescale 1ns/1ps
module tb_cpu_mem_host;
  localparam int DUMP_LEN = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  iram_addr;
  logic [15:0] iram_dout;
  logic [7:0]  dram_addr;
  logic [7:0]  dram_din;
  logic        dram_write;
  logic [7:0]  dram_dout;
  logic        start;
  logic        idle;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
`ifdef CPU_MEM_HOST_CYCLE_COUNT_EN
  logic [31:0] run_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] iram_m [256];
  bit          iram_k [256];
  logic [7:0]  dram_m [256];
  bit          dram_k [256];
  int          wptr;

  typedef struct {
    logic [7:0]  ia;
    logic [7:0]  da;
    logic [15:0] ei;
    logic [7:0]  ed;
  } rb_t;

  always #5 clk = ~clk;

  cpu_mem_host #(.IRAM_DEPTH(256), .DRAM_DEPTH(256), .DUMP_LEN(DUMP_LEN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .iram_addr (iram_addr),
    .iram_dout (iram_dout),
    .dram_addr (dram_addr),
    .dram_din  (dram_din),
    .dram_write(dram_write),
    .dram_dout (dram_dout),
    .start     (start),
    .idle      (idle),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
`ifdef CPU_MEM_HOST_CYCLE_COUNT_EN
    ,
    .run_cycles(run_cycles)
`endif
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(bit is_d, logic [15:0] data, bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    while (s_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("s_ready_wait", 32'(s_ready), 32'd1);
    step();
    if (is_d) begin
      dram_m[wptr] = data[7:0];
      dram_k[wptr] = 1'b1;
    end else begin
      iram_m[wptr] = data;
      iram_k[wptr] = 1'b1;
    end
    wptr    = last ? 0 : (wptr + 1) % 256;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 16'($urandom);
    if (!last && $urandom_range(3) == 0) step();
  endtask

  task automatic load_image(bit is_d, int n);
    wptr = 0;
    for (int i = 0; i < n; i++) send_beat(is_d, 16'($urandom), i == n - 1);
  endtask

  task automatic check_start();
    check("start_pulse", 32'(start), 32'd1);
    check("busy_in_start", 32'(busy), 32'd1);
    check("s_ready_low_start", 32'(s_ready), 32'd0);
    step();
    check("start_one_cycle", 32'(start), 32'd0);
  endtask

  // CPU model: random fetches, loads and stores while idle is low; host beats offered but must be ignored.
  task automatic cpu_run(int nbusy);
    logic [15:0] ei;
    logic [7:0]  ed;
    bit          ki;
    bit          kd;
    idle    = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < nbusy; c++) begin
      iram_addr  = 8'($urandom);
      dram_addr  = 8'($urandom);
      dram_din   = 8'($urandom);
      dram_write = 1'($urandom_range(1));
      ei = iram_m[iram_addr];
      ki = iram_k[iram_addr];
      ed = dram_m[dram_addr];
      kd = dram_k[dram_addr];
      if (dram_write) begin
        dram_m[dram_addr] = dram_din;
        dram_k[dram_addr] = 1'b1;
      end
      step();
      if (ki) check("iram_read", 32'(iram_dout), 32'(ei));
      if (kd) check("dram_read", 32'(dram_dout), 32'(ed));
    end
    dram_write = 1'b0;
    s_valid    = 1'b0;
    idle       = 1'b1;
  endtask

  task automatic dump_check(bit stall);
    int i = 0;
    int n = 0;
    int gap = 0;
    bit prev_stall = 1'b0;
    m_ready = 1'b0;
    while (m_valid !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    check("dump_first_latency", 32'(m_valid === 1'b1 && n <= 3), 32'd1);
    n = 0;
    while (i < DUMP_LEN && n < 400) begin
      m_ready = stall ? 1'($urandom_range(1)) : 1'b1;
      if (m_valid === 1'b1) begin
        gap = 0;
        check("dump_data", 32'(m_data), 32'(dram_m[i]));
        check("dump_last", 32'(m_last), 32'(i == DUMP_LEN - 1));
        prev_stall = !m_ready;
        if (m_ready) i++;
      end else begin
        check("dump_valid_held", 32'(prev_stall), 32'd0);
        gap++;
        check("dump_gap", 32'(gap > 1), 32'd0);
      end
      step();
      n++;
    end
    m_ready = 1'b0;
    check("dump_count", i, DUMP_LEN);
    check("m_valid_after_last", 32'(m_valid), 32'd0);
    n = 0;
    while (s_ready !== 1'b1 && n < 3) begin
      step();
      n++;
    end
    check("reload_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic run_round(int ni, int nd, int nbusy, bit stall, bit poke);
    if (poke) begin
      dram_addr  = 8'd5;
      dram_din   = ~dram_m[5];
      dram_write = 1'b1;
    end
    load_image(1'b0, ni);
    load_image(1'b1, nd);
    dram_write = 1'b0;
    check_start();
    cpu_run(nbusy);
    dump_check(stall);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rb_t         tbl [4];
    logic [7:0]  old;
    int          n;

    tbl[0] = '{8'd0, 8'd0, 16'h0215, 8'h07};
    tbl[1] = '{8'd1, 8'd1, 16'h0000, 8'h09};
    tbl[2] = '{8'd0, 8'd1, 16'h0215, 8'h09};
    tbl[3] = '{8'd1, 8'd0, 16'h0000, 8'h07};

    rstn = 1'b0; idle = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    iram_addr = '0; dram_addr = '0; dram_din = '0; dram_write = 1'b0;
    repeat (3) step();
    check("rst_iram_dout", 32'(iram_dout), 32'd0);
    check("rst_dram_dout", 32'(dram_dout), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    step();
    check("rel_s_ready", 32'(s_ready), 32'd1);
    check("rel_start", 32'(start), 32'd0);
    check("rel_m_valid", 32'(m_valid), 32'd0);

    // Round A: oversize images wrap and leave both RAMs fully known.
    run_round(300, 260, 20, 1'b0, 1'b0);

    // Round B: fixed program, table readback, read-during-write.
    wptr = 0;
    send_beat(1'b0, 16'h0215, 1'b0);
    send_beat(1'b0, 16'h0000, 1'b1);
    wptr = 0;
    send_beat(1'b1, 16'h0007, 1'b0);
    send_beat(1'b1, 16'h0009, 1'b1);
    check_start();
    foreach (tbl[k]) begin
      iram_addr = tbl[k].ia;
      dram_addr = tbl[k].da;
      step();
      check("tbl_iram", 32'(iram_dout), 32'(tbl[k].ei));
      check("tbl_dram", 32'(dram_dout), 32'(tbl[k].ed));
    end
    old        = dram_m[3];
    dram_addr  = 8'd3;
    dram_din   = 8'h5A;
    dram_write = 1'b1;
    step();
    dram_write = 1'b0;
    check("raw_old", 32'(dram_dout), 32'(old));
    step();
    check("raw_new", 32'(dram_dout), 32'h5A);
    dram_m[3] = 8'h5A;
    cpu_run(10);
    dump_check(1'b0);

    // Round C: stores outside S_RUN ignored, random dump backpressure, 10 busy cycles.
    run_round(6, 3, 10, 1'b1, 1'b1);
`ifdef CPU_MEM_HOST_CYCLE_COUNT_EN
    check("run_cycles", 32'(run_cycles >= 32'd10 && run_cycles <= 32'd12), 32'd1);
`endif

    // Round D: reset in the middle of a dump.
    load_image(1'b0, 4);
    load_image(1'b1, 4);
    check_start();
    cpu_run(3);
    n = 0;
    while (m_valid !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    m_ready = 1'b1;
    repeat (3) step();
    check("mid_dump_valid", 32'(m_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_m_last", 32'(m_last), 32'd0);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    m_ready = 1'b0;
    #10;
    rstn = 1'b1;
    step();
    check("post_abort_s_ready", 32'(s_ready), 32'd1);
    check("post_abort_m_valid", 32'(m_valid), 32'd0);

    // Round E/F: random sizes after the abort, then single-beat images.
    run_round(int'($urandom_range(40, 1)), int'($urandom_range(40, 1)), int'($urandom_range(15, 1)), 1'b1, 1'b0);
    run_round(1, 1, 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
